// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: segment bit positions,
// scan states and the hex-to-segment decode table (active-high a..g).
package seven_seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_COUNT = SEG_G - SEG_A + 1;

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_SHOW = 1'b1
    } scan_state_t;

    // Index 0 is the glyph for nibble 0; bit SEG_A is segment a.
    localparam logic [SEG_COUNT-1:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [SEG_COUNT-1:0] hex_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high segment pattern.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0]           nibble,
    output logic [SEG_COUNT-1:0] seg
);

    // Plain table lookup; polarity is handled by the scanner.
    always_comb begin
        seg = hex_seg(nibble);
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with tear-free display
// updates, anti-ghosting dead time and optional leading-zero blanking.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_DEAD | start of a digit period, all digit enables off
// ST_SHOW | selected digit enabled, segments driven from display reg
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 4,
    parameter int ACTIVE_LOW  = 1,
    parameter int LZ_BLANK    = 0
) (
    input  logic        clk,
    input  logic        p_async_reset,
    input  logic [15:0] value_i,
    input  logic        load_i,
    input  logic [3:0]  dp_i,
    input  logic        blank_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [3:0]  digit_o,
    output logic        frame_o
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] TC_CNT   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] DEAD_CNT = PW'(DEAD_CYCLES);
    localparam scan_state_t ST_START   = (DEAD_CYCLES == 0) ? ST_SHOW : ST_DEAD;

    if (REFRESH_DIV < DEAD_CYCLES + 2) begin : g_bad_refresh_div
        $error("seven_seg_scan: REFRESH_DIV must be at least DEAD_CYCLES+2");
    end

    logic [PW-1:0]  presc, presc_next;
    logic [1:0]     idx, idx_next;
    logic           tc, frame_evt;
    scan_state_t    state, state_next;

    logic [15:0]    disp_val, disp_val_next, pend_val;
    logic [3:0]     disp_dp, disp_dp_next, pend_dp;
    logic           pend_flag;

    logic [3:0]     nibble;
    logic [6:0]     seg_dec;
    logic [1:0]     hi_digit;
    logic           lz_off;

    logic [6:0]     seg_q;
    logic           dp_q;
    logic [3:0]     dig_q;
    logic           frame_q;

    // Prescaler wrap and digit index advance at terminal count.
    always_comb begin
        tc         = (presc == TC_CNT);
        presc_next = tc ? '0 : presc + 1'b1;
        idx_next   = tc ? idx + 2'd1 : idx;
        frame_evt  = tc && (idx == 2'd3);
    end

    // Scan FSM next state: dead time ends when the prescaler reaches DEAD_CNT.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_DEAD: if (presc_next == DEAD_CNT) state_next = ST_SHOW;
            ST_SHOW: if (tc) state_next = ST_START;
            default: state_next = ST_START;
        endcase
    end

    // Scan state registers.
    always_ff @(posedge clk or posedge p_async_reset) begin
        if (p_async_reset) begin
            presc <= '0;
            idx   <= 2'd0;
            state <= ST_START;
        end else begin
            presc <= presc_next;
            idx   <= idx_next;
            state <= state_next;
        end
    end

    // Display register only changes at the frame boundary; a load landing
    // on the boundary itself bypasses pending so it is never a frame late.
    always_comb begin
        disp_val_next = disp_val;
        disp_dp_next  = disp_dp;
        if (frame_q) begin
            if (load_i) begin
                disp_val_next = value_i;
                disp_dp_next  = dp_i;
            end else if (pend_flag) begin
                disp_val_next = pend_val;
                disp_dp_next  = pend_dp;
            end
        end
    end

    // Pending and display registers.
    always_ff @(posedge clk or posedge p_async_reset) begin
        if (p_async_reset) begin
            disp_val  <= 16'h0000;
            disp_dp   <= 4'h0;
            pend_val  <= 16'h0000;
            pend_dp   <= 4'h0;
            pend_flag <= 1'b0;
        end else begin
            disp_val <= disp_val_next;
            disp_dp  <= disp_dp_next;
            if (frame_q) begin
                pend_flag <= 1'b0;
            end else if (load_i) begin
                pend_val  <= value_i;
                pend_dp   <= dp_i;
                pend_flag <= 1'b1;
            end
        end
    end

    // Digit selection and leading-zero detection on the value being shown.
    always_comb begin
        nibble   = disp_val_next[{idx, 2'b00} +: 4];
        hi_digit = 2'd0;
        for (int k = 1; k < 4; k++) begin
            if (disp_val_next[k*4 +: 4] != 4'h0) hi_digit = 2'(k);
        end
        lz_off = (LZ_BLANK != 0) && (idx > hi_digit);
    end

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    // Output registers, active-high internally.
    always_ff @(posedge clk or posedge p_async_reset) begin
        if (p_async_reset) begin
            seg_q   <= 7'h00;
            dp_q    <= 1'b0;
            dig_q   <= 4'h0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= frame_evt;
            if (state == ST_SHOW) begin
                dig_q <= 4'b0001 << idx;
                if (blank_i || lz_off) begin
                    seg_q <= 7'h00;
                    dp_q  <= 1'b0;
                end else begin
                    seg_q <= seg_dec;
                    dp_q  <= disp_dp_next[idx];
                end
            end else begin
                dig_q <= 4'h0;
                seg_q <= 7'h00;
                dp_q  <= 1'b0;
            end
        end
    end

    assign seg_o   = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign dp_o    = (ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
    assign digit_o = (ACTIVE_LOW != 0) ? ~dig_q : dig_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: two instances (plain polarity, and inverted
// with leading-zero blanking) driven by the same stimulus and checked
// every cycle against a cycle-count based model, plus literal spot checks.
module tb_seven_seg_scan;

    localparam int RD = 8;
    localparam int DC = 2;
    localparam int FRAME = 4 * RD;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  dp = 4'h0;
    logic        blank = 1'b0;

    logic [6:0]  a_seg, b_seg;
    logic        a_dp, b_dp, a_frame, b_frame;
    logic [3:0]  a_dig, b_dig;

    int checks = 0;
    int failures = 0;

    seven_seg_scan #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC), .ACTIVE_LOW(0), .LZ_BLANK(0)) dut_a (
        .clk(clk), .p_async_reset(rst), .value_i(value), .load_i(load), .dp_i(dp),
        .blank_i(blank), .seg_o(a_seg), .dp_o(a_dp), .digit_o(a_dig), .frame_o(a_frame)
    );

    seven_seg_scan #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC), .ACTIVE_LOW(1), .LZ_BLANK(1)) dut_b (
        .clk(clk), .p_async_reset(rst), .value_i(value), .load_i(load), .dp_i(dp),
        .blank_i(blank), .seg_o(b_seg), .dp_o(b_dp), .digit_o(b_dig), .frame_o(b_frame)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: everything follows from the number of clock edges since reset.
    int          ecnt;
    int          q, p, d, hi;
    bit          show;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_ddp, m_pdp;
    bit          m_pv;
    logic [6:0]  exp_seg_a, exp_seg_b, exp_seg_bn;
    logic        exp_dp_a, exp_dp_b, exp_dp_bn, exp_frame;
    logic [3:0]  exp_dig, exp_dig_n;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ecnt = 0; m_disp = 16'h0; m_pend = 16'h0; m_ddp = 4'h0; m_pdp = 4'h0; m_pv = 0;
            exp_seg_a = 7'h00; exp_seg_b = 7'h00; exp_dp_a = 0; exp_dp_b = 0;
            exp_dig = 4'h0; exp_frame = 0;
        end else begin
            ecnt++;
            // The frame pulse was visible during the cycle that just ended.
            if (ecnt >= 2 && (ecnt - 2) % FRAME == FRAME - 1) begin
                if (load) begin
                    m_disp = value; m_ddp = dp;
                end else if (m_pv) begin
                    m_disp = m_pend; m_ddp = m_pdp;
                end
                m_pv = 0;
            end else if (load) begin
                m_pend = value; m_pdp = dp; m_pv = 1;
            end
            q = ecnt - 1;
            p = q % RD;
            d = (q / RD) % 4;
            show = (p >= DC);
            hi = 0;
            for (int k = 0; k < 4; k++) if (m_disp[4*k +: 4] != 4'h0) hi = k;
            exp_dig   = show ? (4'b0001 << d) : 4'h0;
            exp_seg_a = (show && !blank) ? SEG_TAB[m_disp[4*d +: 4]] : 7'h00;
            exp_dp_a  = show && !blank && m_ddp[d];
            exp_seg_b = (show && !blank && d <= hi) ? SEG_TAB[m_disp[4*d +: 4]] : 7'h00;
            exp_dp_b  = show && !blank && (d <= hi) && m_ddp[d];
            exp_frame = (q % FRAME) == FRAME - 1;
        end
        exp_seg_bn = ~exp_seg_b;
        exp_dp_bn  = ~exp_dp_b;
        exp_dig_n  = ~exp_dig;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("seg_a", 16'(a_seg), 16'(exp_seg_a));
        chk("dp_a", 16'(a_dp), 16'(exp_dp_a));
        chk("digit_a", 16'(a_dig), 16'(exp_dig));
        chk("frame_a", 16'(a_frame), 16'(exp_frame));
        chk("seg_b", 16'(b_seg), 16'(exp_seg_bn));
        chk("dp_b", 16'(b_dp), 16'(exp_dp_bn));
        chk("digit_b", 16'(b_dig), 16'(exp_dig_n));
        chk("frame_b", 16'(b_frame), 16'(exp_frame));
    end

    task automatic to_edge(input int n);
        int guard = 0;
        while (ecnt != n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (ecnt != n) begin
            checks++;
            failures++;
            $display("FAIL to_edge_timeout actual=%0d required=%0d", ecnt, n);
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        to_edge(3);
        chk("lit_reset_digit0_seg", 16'(a_seg), 16'h3F);
        chk("lit_reset_digit0_en", 16'(a_dig), 16'h1);
        chk("lit_reset_digit0_en_inv", 16'(b_dig), 16'hE);

        to_edge(11);
        value = 16'hBEEF; dp = 4'b0100; load = 1'b1;
        to_edge(12);
        load = 1'b0;
        to_edge(20);
        chk("lit_no_tear_seg", 16'(a_seg), 16'h3F);
        chk("lit_no_tear_dig", 16'(a_dig), 16'h4);
        to_edge(32);
        chk("lit_frame_pulse", 16'(a_frame), 16'h1);
        to_edge(35);
        chk("lit_beef_d0", 16'(a_seg), 16'h71);
        to_edge(43);
        chk("lit_beef_d1", 16'(a_seg), 16'h79);
        to_edge(51);
        chk("lit_beef_d2", 16'(a_seg), 16'h79);
        chk("lit_beef_dp2", 16'(a_dp), 16'h1);
        to_edge(59);
        chk("lit_beef_d3", 16'(a_seg), 16'h7C);

        to_edge(64);
        value = 16'h1234; dp = 4'h0; load = 1'b1;
        to_edge(65);
        load = 1'b0;
        to_edge(67);
        chk("lit_direct_d0", 16'(a_seg), 16'h66);
        to_edge(70);
        value = 16'h1111; load = 1'b1;
        to_edge(71);
        load = 1'b0;
        to_edge(80);
        value = 16'h2222; load = 1'b1;
        to_edge(81);
        load = 1'b0;
        to_edge(91);
        chk("lit_direct_d3", 16'(a_seg), 16'h06);
        to_edge(99);
        chk("lit_last_wins_d0", 16'(a_seg), 16'h5B);
        to_edge(107);
        chk("lit_last_wins_d1", 16'(a_seg), 16'h5B);

        to_edge(110);
        value = 16'h0040; load = 1'b1;
        to_edge(111);
        load = 1'b0;
        to_edge(131);
        chk("lit_lz_d0", 16'(b_seg), 16'h40);
        chk("lit_nolz_d0", 16'(a_seg), 16'h3F);
        to_edge(139);
        chk("lit_lz_d1", 16'(b_seg), 16'h19);
        to_edge(147);
        chk("lit_lz_d2", 16'(b_seg), 16'h7F);
        chk("lit_nolz_d2", 16'(a_seg), 16'h3F);
        to_edge(155);
        chk("lit_lz_d3", 16'(b_seg), 16'h7F);
        chk("lit_lz_d3_dig", 16'(b_dig), 16'h7);

        to_edge(163);
        blank = 1'b1;
        to_edge(165);
        chk("lit_blank_seg_inv", 16'(b_seg), 16'h7F);
        chk("lit_blank_dp_inv", 16'(b_dp), 16'h1);
        chk("lit_blank_dig_inv", 16'(b_dig), 16'hE);
        chk("lit_blank_seg", 16'(a_seg), 16'h00);
        to_edge(168);
        blank = 1'b0;
        to_edge(171);
        chk("lit_unblank_d1", 16'(a_seg), 16'h66);

        to_edge(172);
        value = 16'hAAAA; load = 1'b1;
        to_edge(173);
        load = 1'b0;
        to_edge(180);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("lit_rst_dig", 16'(a_dig), 16'h0);
        chk("lit_rst_seg", 16'(a_seg), 16'h00);
        chk("lit_rst_dig_inv", 16'(b_dig), 16'hF);
        chk("lit_rst_seg_inv", 16'(b_seg), 16'h7F);
        chk("lit_rst_dp_inv", 16'(b_dp), 16'h1);
        @(negedge clk);
        rst = 1'b0;
        to_edge(3);
        chk("lit_after_rst_d0", 16'(a_seg), 16'h3F);
        to_edge(35);
        chk("lit_pending_dropped", 16'(a_seg), 16'h3F);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load  = ($urandom_range(0, 15) == 0);
            value = 16'($urandom);
            if ($urandom_range(0, 1) == 1) value = value >> (4 * $urandom_range(0, 3));
            dp = 4'($urandom);
            if ($urandom_range(0, 63) == 0) blank = ~blank;
            if ($urandom_range(0, 799) == 0) begin
                #1 rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
